// File: rtl/tamagotchi_pkg.sv
// -----------------------------------------------------------------------------
// tamagotchi_pkg
// Shared definitions for the tamagotchi input stage:
//   - button index map into the btn_* vectors
//   - default number of buttons
//   - per-button press state machine encoding
// -----------------------------------------------------------------------------
package tamagotchi_pkg;

  // Button positions inside every N_BTN-wide vector.
  localparam int BTN_SALUD = 0;
  localparam int BTN_ALI   = 1;
  localparam int BTN_RESET = 2;
  localparam int BTN_TEST  = 3;

  localparam int N_BTN_DEFAULT = 4;

  // Per-button press tracking:
  //   ST_IDLE    : debounced level is "not pressed"
  //   ST_PRESSED : pressed, hold counter running
  //   ST_HELD    : long-press reported, waiting for release
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HELD    = 2'd2
  } btn_state_t;

endpackage

// File: rtl/tamagotchi_button_conditioner_if.sv
// -----------------------------------------------------------------------------
// tamagotchi_button_conditioner_if
// Bundle between the raw pushbutton pads / game FSM and the button conditioner.
//   btn_raw     : raw pad inputs (asynchronous to clk)
//   evt_ack     : per-button acknowledge, clears both sticky flags
//   btn_level   : debounced pressed state, 1 = pressed
//   btn_press   : 1-cycle pulse on debounced press
//   btn_release : 1-cycle pulse on debounced release
//   btn_long    : 1-cycle pulse when a hold reaches the long-press time
//   btn_held    : high from the long pulse until the debounced release
//   evt_press   : sticky press flag
//   evt_long    : sticky long-press flag
// Modports:
//   master : side that supplies pads/acks and consumes events (FSM, bench)
//   slave  : the conditioner itself
// -----------------------------------------------------------------------------
interface tamagotchi_button_conditioner_if
  import tamagotchi_pkg::*;
#(
  parameter int N_BTN = N_BTN_DEFAULT
);

  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] evt_ack;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic [N_BTN-1:0] btn_long;
  logic [N_BTN-1:0] btn_held;
  logic [N_BTN-1:0] evt_press;
  logic [N_BTN-1:0] evt_long;

  modport master (
    output btn_raw,
    output evt_ack,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  btn_long,
    input  btn_held,
    input  evt_press,
    input  evt_long
  );

  modport slave (
    input  btn_raw,
    input  evt_ack,
    output btn_level,
    output btn_press,
    output btn_release,
    output btn_long,
    output btn_held,
    output evt_press,
    output evt_long
  );

endinterface

// File: rtl/tamagotchi_button_conditioner_cell.sv
// -----------------------------------------------------------------------------
// button_debounce_cell
// Conditioning for a single pushbutton:
//   polarity normalisation -> 2-flop synchronizer -> debounce counter ->
//   IDLE/PRESSED/HELD state machine -> sticky event flags.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   btn_raw_i     : raw pad level (asynchronous)
//   evt_ack_i     : clears both sticky flags (a simultaneous set wins)
//   btn_level_o   : debounced pressed state
//   btn_press_o   : pulse on debounced press
//   btn_release_o : pulse on debounced release
//   btn_long_o    : pulse when the hold reaches LONG_PRESS_CYCLES
//   btn_held_o    : high while in HELD
//   evt_press_o   : sticky press flag
//   evt_long_o    : sticky long-press flag
// -----------------------------------------------------------------------------
module button_debounce_cell
  import tamagotchi_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 1_000_000,
  parameter int LONG_PRESS_CYCLES = 250_000_000,
  parameter int ACTIVE_LOW        = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw_i,
  input  logic evt_ack_i,
  output logic btn_level_o,
  output logic btn_press_o,
  output logic btn_release_o,
  output logic btn_long_o,
  output logic btn_held_o,
  output logic evt_press_o,
  output logic evt_long_o
);

  localparam int DCNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HCNT_W = (LONG_PRESS_CYCLES > 1) ? $clog2(LONG_PRESS_CYCLES) : 1;

  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(LONG_PRESS_CYCLES - 1);

  logic              pressed_raw;
  logic              sync1_q, sync2_q;
  logic              level_q, level_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  btn_state_t        state_q, state_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              long_q, long_d;
  logic              evtp_q, evtp_d;
  logic              evtl_q, evtl_d;

  logic              differ;
  logic              toggle;
  logic              rise;
  logic              fall;

  // Normalise to 1 = pressed before synchronising, so the synchronizer's
  // reset value of 0 always means "not pressed".
  assign pressed_raw = (ACTIVE_LOW != 0) ? ~btn_raw_i : btn_raw_i;

  // Synchronizer: two flops, first one may go metastable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pressed_raw;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    // Debounce: count consecutive cycles of disagreement with the accepted
    // level; any agreeing cycle restarts the count. The level flips when the
    // disagreement has lasted DEBOUNCE_CYCLES cycles.
    differ  = sync2_q ^ level_q;
    toggle  = differ && (dcnt_q == DCNT_LAST);
    dcnt_d  = '0;
    if (differ && !toggle) begin
      dcnt_d = dcnt_q + DCNT_W'(1);
    end
    level_d = level_q ^ toggle;
    rise    = toggle && !level_q;
    fall    = toggle && level_q;

    // Press tracking. A release always takes priority over reaching the
    // long-press count, so a release on that very cycle yields no long event.
    state_d = state_q;
    hcnt_d  = hcnt_q;
    long_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d = ST_PRESSED;
          hcnt_d  = HCNT_W'(1);
        end
      end
      ST_PRESSED: begin
        if (fall) begin
          state_d = ST_IDLE;
        end else if (hcnt_q == HCNT_LAST) begin
          state_d = ST_HELD;
          long_d  = 1'b1;
        end else begin
          hcnt_d = hcnt_q + HCNT_W'(1);
        end
      end
      ST_HELD: begin
        // hcnt stays frozen so no repeat long event can fire.
        if (fall) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    press_d   = rise;
    release_d = fall;

    // Sticky flags follow the registered pulses; a set beats a same-cycle ack.
    evtp_d = press_q | (evtp_q & ~evt_ack_i);
    evtl_d = long_q  | (evtl_q & ~evt_ack_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q   <= 1'b0;
      dcnt_q    <= '0;
      hcnt_q    <= '0;
      state_q   <= ST_IDLE;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      evtp_q    <= 1'b0;
      evtl_q    <= 1'b0;
    end else begin
      level_q   <= level_d;
      dcnt_q    <= dcnt_d;
      hcnt_q    <= hcnt_d;
      state_q   <= state_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      evtp_q    <= evtp_d;
      evtl_q    <= evtl_d;
    end
  end

  assign btn_level_o   = level_q;
  assign btn_press_o   = press_q;
  assign btn_release_o = release_q;
  assign btn_long_o    = long_q;
  // HELD is entered on the long pulse edge and left on the release edge,
  // which is exactly the btn_held window.
  assign btn_held_o    = (state_q == ST_HELD);
  assign evt_press_o   = evtp_q;
  assign evt_long_o    = evtl_q;

endmodule

// File: rtl/tamagotchi_button_conditioner.sv
// -----------------------------------------------------------------------------
// tamagotchi_button_conditioner
// Input stage for the tamagotchi FSM: synchronizes and debounces every board
// pushbutton, reports clean levels, press/release/long-press pulses and
// sticky press/long flags the FSM clears with an acknowledge.
// Parameters:
//   N_BTN             : number of buttons (index map in tamagotchi_pkg)
//   DEBOUNCE_CYCLES   : stable cycles to accept a change (>= 2)
//   LONG_PRESS_CYCLES : cycles of press before a long event (> DEBOUNCE_CYCLES)
//   ACTIVE_LOW        : 1 = raw 0 means pressed
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : slave side of tamagotchi_button_conditioner_if (pads, acks, events)
// -----------------------------------------------------------------------------
module tamagotchi_button_conditioner
  import tamagotchi_pkg::*;
#(
  parameter int N_BTN             = N_BTN_DEFAULT,
  parameter int DEBOUNCE_CYCLES   = 1_000_000,
  parameter int LONG_PRESS_CYCLES = 250_000_000,
  parameter int ACTIVE_LOW        = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  tamagotchi_button_conditioner_if.slave bus
);

  logic [N_BTN-1:0] level_w;
  logic [N_BTN-1:0] press_w;
  logic [N_BTN-1:0] release_w;
  logic [N_BTN-1:0] long_w;
  logic [N_BTN-1:0] held_w;
  logic [N_BTN-1:0] evtp_w;
  logic [N_BTN-1:0] evtl_w;

  // One fully independent cell per button.
  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    button_debounce_cell #(
      .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES),
      .ACTIVE_LOW        (ACTIVE_LOW)
    ) u_cell (
      .clk           (clk),
      .rst           (rst),
      .btn_raw_i     (bus.btn_raw[i]),
      .evt_ack_i     (bus.evt_ack[i]),
      .btn_level_o   (level_w[i]),
      .btn_press_o   (press_w[i]),
      .btn_release_o (release_w[i]),
      .btn_long_o    (long_w[i]),
      .btn_held_o    (held_w[i]),
      .evt_press_o   (evtp_w[i]),
      .evt_long_o    (evtl_w[i])
    );
  end

  assign bus.btn_level   = level_w;
  assign bus.btn_press   = press_w;
  assign bus.btn_release = release_w;
  assign bus.btn_long    = long_w;
  assign bus.btn_held    = held_w;
  assign bus.evt_press   = evtp_w;
  assign bus.evt_long    = evtl_w;

endmodule
